// File: rtl/bram_multiport.sv
// bram_multiport
//   N-read / 1-write block RAM for weight, bias and activation storage.
//   Reads run through a RD_LATENCY-deep register pipeline with per-lane valid
//   flags. Writes are bit-masked. A clear engine zeroes the whole array on
//   request or, optionally, on every reset release.
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset (array contents are kept)
//   ena_i       global enable for user writes and read issues
//   wr_ena_i    write strobe
//   wr_addr_i   write address
//   wr_mask_i   per-bit write mask, 1 = bit updated
//   data_i      write data
//   rd_ena_i    per-lane read issue
//   rd_addr_i   lane k address at [k*AW +: AW]
//   data_o      lane k data at [k*WORD_LEN +: WORD_LEN], 0 when not valid
//   rd_valid_o  lane k data valid
//   clear_i     request a clear of the whole array (taken only when idle)
//   busy_o      clear engine active; user accesses are ignored
module bram_multiport #(
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned WORD_LEN       = 32,
    parameter int unsigned NUM_RD         = 2,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned WR_MODE        = 0,
    parameter string       INIT_FILE      = "",
    parameter int unsigned CLEAR_ON_RESET = 0,
    localparam int unsigned AW            = $clog2(DEPTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ena_i,
    input  logic                       wr_ena_i,
    input  logic [AW-1:0]              wr_addr_i,
    input  logic [WORD_LEN-1:0]        wr_mask_i,
    input  logic [WORD_LEN-1:0]        data_i,
    input  logic [NUM_RD-1:0]          rd_ena_i,
    input  logic [NUM_RD*AW-1:0]       rd_addr_i,
    output logic [NUM_RD*WORD_LEN-1:0] data_o,
    output logic [NUM_RD-1:0]          rd_valid_o,
    input  logic                       clear_i,
    output logic                       busy_o
);

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_CLEAR  = 1'b1;
    // One extra bit so that DEPTH itself is representable for range checks.
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [WORD_LEN-1:0] mem [DEPTH];

    logic [0:0]          state_q, state_d;
    logic [AW-1:0]       clr_addr_q, clr_addr_d;
    logic                idle;
    logic                wr_in_range;
    logic                wr_fire;
    logic [WORD_LEN-1:0] wr_word;

    logic [NUM_RD-1:0]          rd_issue;
    logic [NUM_RD*WORD_LEN-1:0] rd_word;

    logic [NUM_RD*WORD_LEN-1:0] pipe_data_q  [RD_LATENCY];
    logic [NUM_RD-1:0]          pipe_valid_q [RD_LATENCY];

    assign idle        = (state_q == ST_IDLE);
    assign busy_o      = (state_q == ST_CLEAR);
    assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_EXT);
    assign wr_fire     = idle & ena_i & wr_ena_i & wr_in_range;
    // Masked merge; also the word a write-first reader sees on a collision.
    assign wr_word     = (mem[wr_addr_i] & ~wr_mask_i) | (data_i & wr_mask_i);

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage: not reset, only the clear engine or user writes modify it
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_addr_q] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr_i] <= wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Read issue: out-of-range lanes are valid and return 0
    // ------------------------------------------------------------------
    always_comb begin
        rd_issue = '0;
        rd_word  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (idle && ena_i && rd_ena_i[k]) begin
                rd_issue[k] = 1'b1;
                if ({1'b0, rd_addr_i[k*AW +: AW]} < DEPTH_EXT) begin
                    if ((WR_MODE != 0) && wr_fire && (rd_addr_i[k*AW +: AW] == wr_addr_i)) begin
                        rd_word[k*WORD_LEN +: WORD_LEN] = wr_word;
                    end else begin
                        rd_word[k*WORD_LEN +: WORD_LEN] = mem[rd_addr_i[k*AW +: AW]];
                    end
                end
            end
        end
    end

    // Pipeline advances every cycle; idle lanes carry zero data so nothing stale leaks out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                pipe_data_q[s]  <= '0;
                pipe_valid_q[s] <= '0;
            end
        end else begin
            pipe_data_q[0]  <= rd_word;
            pipe_valid_q[0] <= rd_issue;
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipe_data_q[s]  <= pipe_data_q[s-1];
                pipe_valid_q[s] <= pipe_valid_q[s-1];
            end
        end
    end

    assign data_o     = pipe_data_q[RD_LATENCY-1];
    assign rd_valid_o = pipe_valid_q[RD_LATENCY-1];

endmodule
